xml_stream_arbiter: RTL and testbench

Round-robin arbiter that shares one `XMLDecoder` instance between `NREQ` byte-stream sources. It grants the decoder one whole message at a time and pulses `newMsg` before each message so the decoder restarts its parse state. After the last byte it holds off the next grant for a drain window, and it tags decoder output with the owning source so downstream logic can demultiplex `out`/`isTag`/etc. The block sits directly in front of `XMLDecoder`.

---
 rtl/xml_stream_arbiter_pkg.sv | 19 +
 rtl/xml_stream_arbiter_rr_pick.sv | 28 ++
 rtl/xml_stream_arbiter.sv | 146 ++++++++++++++
 tb/tb_xml_stream_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xml_stream_arbiter_pkg.sv
// Shared types and helpers for the XML decoder stream arbiter.
package xml_stream_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } arb_state_e;

  // Width of a grant index for n requesters (at least one bit).
  function automatic int unsigned owner_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xml_stream_arbiter_rr_pick.sv
// Combinational round-robin select: first set request after i_last, wrapping.
module xml_stream_arbiter_rr_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_grant,
  output logic         o_any
);

  logic [W-1:0] w_idx;

  // Scan i_last+1 .. i_last+N modulo N, keep the first hit.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = W'((32'(i_last) + k) % N);
      if (!o_any && i_req[w_idx]) begin
        o_grant = w_idx;
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xml_stream_arbiter.sv
// Round-robin arbiter sharing one XML decoder between NREQ byte streams,
// one whole message per grant, with a drain gap between messages.
module xml_stream_arbiter
  import xml_stream_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ    = 2,
  parameter  int unsigned LAT     = 1,
  parameter  int unsigned DRAIN   = 2,
  localparam int unsigned OWNER_W = owner_w(NREQ)
) (
  input  logic                   CLOCK,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]      dec_in,
  output logic                   dec_inValid,
  output logic                   dec_newMsg,
  output logic [OWNER_W-1:0]     owner,
  output logic [OWNER_W-1:0]     owner_out,
  output logic                   busy,
  output logic                   msg_done
);

  arb_state_e          r_state, w_state_nxt;
  logic [OWNER_W-1:0]  r_owner, w_owner_nxt;
  logic [OWNER_W-1:0]  r_last_owner, w_last_owner_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0]   r_dec_in, w_dec_in_nxt;
  logic                r_dec_vld, w_dec_vld_nxt;
  logic                r_newmsg, w_newmsg_nxt;
  logic                r_done, w_done_nxt;
  logic                r_busy, w_busy_nxt;
  logic [OWNER_W-1:0]  r_own_pipe [LAT];

  logic [OWNER_W-1:0]  w_pick;
  logic                w_any;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [BYTE_W-1:0]   w_sel_byte;

  xml_stream_arbiter_rr_pick #(
    .N (NREQ),
    .W (OWNER_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_last  (r_last_owner),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  assign w_sel_valid = req_valid[r_owner];
  assign w_sel_last  = req_last[r_owner];
  assign w_sel_byte  = req_data[{r_owner, 3'b000} +: BYTE_W];

  // Only the owner is ready, and only while streaming; decoded from registers.
  always_comb begin
    req_ready = '0;
    if (r_state == S_STREAM) req_ready[r_owner] = 1'b1;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_cnt_nxt        = r_cnt;
    w_dec_in_nxt     = r_dec_in;
    w_dec_vld_nxt    = 1'b0;
    w_newmsg_nxt     = 1'b0;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_owner_nxt  = w_pick;
          w_newmsg_nxt = 1'b1;
          w_state_nxt  = S_START;
        end
      end
      S_START: w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_sel_valid) begin
          w_dec_in_nxt  = w_sel_byte;
          w_dec_vld_nxt = 1'b1;
          if (w_sel_last) begin
            w_done_nxt       = 1'b1;
            w_last_owner_nxt = r_owner;
            w_cnt_nxt        = CNT_W'(DRAIN - 1);
            w_state_nxt      = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= OWNER_W'(NREQ - 1);
      r_cnt        <= '0;
      r_dec_in     <= '0;
      r_dec_vld    <= 1'b0;
      r_newmsg     <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dec_in     <= w_dec_in_nxt;
      r_dec_vld    <= w_dec_vld_nxt;
      r_newmsg     <= w_newmsg_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Delay owner by LAT cycles so it lines up with decoder outValid.
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(LAT); i++) r_own_pipe[i] <= '0;
    end else begin
      r_own_pipe[0] <= r_owner;
      for (int i = 1; i < int'(LAT); i++) r_own_pipe[i] <= r_own_pipe[i-1];
    end
  end

  assign dec_in      = r_dec_in;
  assign dec_inValid = r_dec_vld;
  assign dec_newMsg  = r_newmsg;
  assign owner       = r_owner;
  assign owner_out   = r_own_pipe[LAT-1];
  assign busy        = r_busy;
  assign msg_done    = r_done;

endmodule

// File: tb/tb_xml_stream_arbiter.sv
// Directed bench for xml_stream_arbiter (NREQ=4, LAT=3, DRAIN=2).
module tb_xml_stream_arbiter;

  logic        CLOCK;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  dec_in;
  logic        dec_inValid;
  logic        dec_newMsg;
  logic [1:0]  owner;
  logic [1:0]  owner_out;
  logic        busy;
  logic        msg_done;

  xml_stream_arbiter #(.NREQ(4), .LAT(3), .DRAIN(2)) dut (
    .CLOCK       (CLOCK),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .dec_in      (dec_in),
    .dec_inValid (dec_inValid),
    .dec_newMsg  (dec_newMsg),
    .owner       (owner),
    .owner_out   (owner_out),
    .busy        (busy),
    .msg_done    (msg_done)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Source model per requester.
  string src_str [4];
  int    src_idx [4];
  int    src_rep [4];
  int    src_gap_at [4];
  int    src_gap [4];
  bit    src_act [4];

  // Observation state.
  int         n_new, n_val, n_done, first_v, busy_fall, base;
  int         nm_cyc[$];
  int         dn_cyc[$];
  logic [7:0] got[$];
  int         exp_q[$];
  int         cur_exp;
  logic [7:0] last_seen;
  bit         p_v [3];
  int         p_o [3];
  logic       prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_act();
    return src_act[0] | src_act[1] | src_act[2] | src_act[3];
  endfunction

  task automatic start_src(input int i, input string s, input int reps, input int gap_at, input int gap);
    src_str[i] = s; src_idx[i] = 0; src_rep[i] = reps;
    src_gap_at[i] = gap_at; src_gap[i] = gap; src_act[i] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bit v;
      v = src_act[i] && !(src_idx[i] == src_gap_at[i] && src_gap[i] > 0);
      req_valid[i] = v;
      req_data[i*8 +: 8] = src_act[i] ? src_str[i][src_idx[i]] : 8'h00;
      req_last[i] = src_act[i] && (!v || src_idx[i] == src_str[i].len() - 1);
    end
  endtask

  task automatic clr();
    n_new = 0; n_val = 0; n_done = 0; first_v = -1; busy_fall = -1;
    nm_cyc.delete(); dn_cyc.delete(); got.delete(); exp_q.delete();
  endtask

  task automatic monitor();
    if (dec_newMsg) begin
      n_new++;
      nm_cyc.push_back(cyc);
      cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 7;
      chk("grant_owner", 32'(owner), 32'(cur_exp));
    end
    if (p_v[2]) chk("owner_out_align", 32'(owner_out), 32'(p_o[2]));
    p_v[2] = p_v[1]; p_v[1] = p_v[0]; p_v[0] = dec_inValid;
    p_o[2] = p_o[1]; p_o[1] = p_o[0]; p_o[0] = cur_exp;
    if (dec_inValid) begin
      got.push_back(dec_in);
      last_seen = dec_in;
      n_val++;
      if (first_v < 0) first_v = cyc;
    end else begin
      chk("dec_in_hold", 32'(dec_in), 32'(last_seen));
    end
    if (msg_done) begin
      n_done++;
      dn_cyc.push_back(cyc);
      chk("done_with_byte", 32'(dec_inValid), 32'd1);
    end
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
  endtask

  task automatic step();
    logic [3:0] hs;
    hs = req_valid & req_ready;
    @(posedge CLOCK); #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        src_idx[i]++;
        if (src_idx[i] >= src_str[i].len()) begin
          if (src_rep[i] > 1) begin src_rep[i]--; src_idx[i] = 0; end
          else src_act[i] = 1'b0;
        end
      end else if (src_act[i] && src_idx[i] == src_gap_at[i] && src_gap[i] > 0) begin
        src_gap[i]--;
      end
    end
    monitor();
    drive();
  endtask

  task automatic run_idle(input int max);
    int k;
    k = 0;
    while ((any_act() || busy) && k < max) begin step(); k++; end
    chk("reached_idle", {30'b0, any_act(), busy}, 32'd0);
  endtask

  task automatic chk_bytes(input string tag, input string s);
    chk({tag, "_len"}, 32'(got.size()), 32'(s.len()));
    for (int i = 0; i < s.len(); i++)
      if (i < got.size()) chk(tag, 32'(got[i]), 32'(s[i]));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dec_in"}, 32'(dec_in), 32'd0);
    chk({tag, "_inValid"}, 32'(dec_inValid), 32'd0);
    chk({tag, "_newMsg"}, 32'(dec_newMsg), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
    chk({tag, "_owner_out"}, 32'(owner_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_msg_done"}, 32'(msg_done), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4; i++) begin
      src_act[i] = 1'b0; src_idx[i] = 0; src_rep[i] = 0; src_gap_at[i] = -1; src_gap[i] = 0;
      src_str[i] = "";
    end
    for (int i = 0; i < 3; i++) begin p_v[i] = 1'b0; p_o[i] = 0; end
    cur_exp = 0; last_seen = 8'h00; prev_busy = 1'b0;
    clr();
    reset_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;

    // Reset state.
    #3;
    chk_outputs_zero("reset");
    @(posedge CLOCK); @(posedge CLOCK); #1;
    reset_n = 1'b1;
    step(); step();
    chk_outputs_zero("idle_after_reset");

    // 1: single requester, 8-byte message.
    clr(); base = cyc;
    exp_q = {0};
    start_src(0, "<a>x</a>", 1, -1, 0);
    drive();
    run_idle(60);
    chk("s1_newmsg_cnt", 32'(n_new), 32'd1);
    chk("s1_valid_cnt", 32'(n_val), 32'd8);
    chk("s1_done_cnt", 32'(n_done), 32'd1);
    if (nm_cyc.size() > 0) chk("s1_newmsg_cyc", 32'(nm_cyc[0]), 32'(base + 1));
    chk("s1_first_byte_cyc", 32'(first_v), 32'(base + 3));
    if (dn_cyc.size() > 0) begin
      chk("s1_done_cyc", 32'(dn_cyc[0]), 32'(base + 10));
      chk("s1_busy_fall", 32'(busy_fall), 32'(dn_cyc[0] + 2));
    end
    chk("s1_owner", 32'(owner), 32'd0);
    chk_bytes("s1_bytes", "<a>x</a>");

    // 2: requesters 0 and 1 both continuously busy with 3-byte messages.
    clr(); base = cyc;
    exp_q = {1, 0, 1, 0};
    start_src(0, "A0>", 2, -1, 0);
    start_src(1, "B1>", 2, -1, 0);
    drive();
    run_idle(100);
    chk("s2_newmsg_cnt", 32'(n_new), 32'd4);
    chk("s2_done_cnt", 32'(n_done), 32'd4);
    chk("s2_grants_left", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < nm_cyc.size(); i++)
      chk("s2_newmsg_spacing", 32'(nm_cyc[i] - nm_cyc[i-1]), 32'd7);
    chk_bytes("s2_bytes", "B1>A0>B1>A0>");

    // 3: owner stalls 5 cycles mid-message while another requester waits.
    clr(); base = cyc;
    exp_q = {1, 0};
    start_src(1, "<q>rs>", 1, 3, 5);
    start_src(0, "C0>", 1, -1, 0);
    drive();
    run_idle(100);
    chk("s3_first_byte_cyc", 32'(first_v), 32'(base + 3));
    if (dn_cyc.size() > 0) chk("s3_done_cyc", 32'(dn_cyc[0]), 32'(base + 13));
    if (nm_cyc.size() > 1) chk("s3_second_grant_cyc", 32'(nm_cyc[1]), 32'(base + 16));
    chk("s3_newmsg_cnt", 32'(n_new), 32'd2);
    chk("s3_grants_left", 32'(exp_q.size()), 32'd0);
    chk_bytes("s3_bytes", "<q>rs>C0>");

    // 4: round robin over 4 requesters; requester 2 joins late.
    clr();
    exp_q = {3};
    start_src(3, "D3>", 1, -1, 0);
    drive();
    run_idle(40);
    chk("s4_pre_owner", 32'(owner), 32'd3);
    clr();
    exp_q = {1, 2, 3, 1};
    start_src(1, "E1>", 2, -1, 0);
    start_src(3, "F3>", 1, -1, 0);
    drive();
    k = 0;
    while (n_new == 0 && k < 20) begin step(); k++; end
    chk("s4_first_grant", 32'(n_new), 32'd1);
    start_src(2, "G2>", 1, -1, 0);
    drive();
    run_idle(120);
    chk("s4_newmsg_cnt", 32'(n_new), 32'd4);
    chk("s4_grants_left", 32'(exp_q.size()), 32'd0);
    chk_bytes("s4_bytes", "E1>G2>F3>E1>");

    // 5: reset in the middle of a 10-byte message.
    clr();
    exp_q = {0};
    start_src(0, "<m>abcdef>", 1, -1, 0);
    drive();
    k = 0;
    while (n_val < 3 && k < 20) begin step(); k++; end
    chk("s5_mid_valid_cnt", 32'(n_val), 32'd3);
    chk("s5_mid_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    chk("s5_no_done", 32'(n_done), 32'd0);
    for (int i = 0; i < 4; i++) src_act[i] = 1'b0;
    drive();
    for (int i = 0; i < 3; i++) begin p_v[i] = 1'b0; p_o[i] = 0; end
    last_seen = 8'h00; prev_busy = 1'b0;
    @(posedge CLOCK); @(posedge CLOCK); #1;
    chk("s5_hold_busy", 32'(busy), 32'd0);
    chk("s5_hold_newmsg", 32'(dec_newMsg), 32'd0);
    reset_n = 1'b1;
    step();
    clr(); base = cyc;
    exp_q = {0, 2};
    start_src(2, "I2>", 1, -1, 0);
    start_src(0, "H0>", 1, -1, 0);
    drive();
    run_idle(60);
    if (nm_cyc.size() > 0) chk("s5_regrant_cyc", 32'(nm_cyc[0]), 32'(base + 1));
    chk("s5_newmsg_cnt", 32'(n_new), 32'd2);
    chk("s5_done_cnt", 32'(n_done), 32'd2);
    chk("s5_grants_left", 32'(exp_q.size()), 32'd0);
    chk_bytes("s5_bytes", "H0>I2>");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
